// File: rtl/mnist_pkg.sv
// Shared constants and the streamer state type for the MNIST image path.
package mnist_pkg;

    localparam int IMG_PIXELS = 784;
    localparam int PIX_W      = 8;
    localparam int CLASS_W    = 4;
    localparam int CONF_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        WAIT_RES,
        DONE
    } streamer_state_t;

endpackage

// File: rtl/image_rd_pipe.sv
// Synchronous-memory read stage: one cycle of memory latency plus an output
// register, turning a read-enable strobe into a data/valid stream.
module image_rd_pipe
    import mnist_pkg::*;
#(
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic              rd_en_d1_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_d1_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            rd_en_d1_q <= rd_en_i;
            valid_q    <= rd_en_d1_q;
            // Data is forced to zero between beats so idle cycles are clean.
            data_q     <= rd_en_d1_q ? rdata_i : '0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/image_streamer.sv
// Streams one image from memory into the classifier and collects its result.
// Optional WAIT_RES timeout is enabled by defining IMAGE_STREAMER_TIMEOUT_EN.
module image_streamer #(
    parameter int IMG_PIXELS     = mnist_pkg::IMG_PIXELS,
    parameter int DATA_W         = mnist_pkg::PIX_W,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic [3:0]        nn_prediction,
    input  logic [7:0]        nn_confidence,
    input  logic              nn_valid,
    output logic [3:0]        result_digit,
    output logic [7:0]        result_conf,
    output logic              timeout
);

    import mnist_pkg::streamer_state_t;
    import mnist_pkg::IDLE;
    import mnist_pkg::STREAM;
    import mnist_pkg::DRAIN;
    import mnist_pkg::WAIT_RES;
    import mnist_pkg::DONE;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

    if ((2 ** ADDR_W) < IMG_PIXELS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("image_streamer: ADDR_W too small or TIMEOUT_CYCLES < 1");
    end

    streamer_state_t   state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;
    logic              drain_q;
    logic              done_q;
    logic [3:0]        digit_q;
    logic [7:0]        conf_q;

`ifdef IMAGE_STREAMER_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt_q;
    logic            timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            drain_q    <= 1'b0;
            done_q     <= 1'b0;
            digit_q    <= '0;
            conf_q     <= '0;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= STREAM;
                        rd_en_q   <= 1'b1;
                        addr_q    <= '0;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                STREAM: begin
                    if (addr_q == LAST_ADDR) begin
                        rd_en_q <= 1'b0;
                        drain_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                // Two cycles cover the memory latency and the output register.
                DRAIN: begin
                    if (drain_q) begin
                        state_q    <= WAIT_RES;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (nn_valid) begin
                        digit_q <= nn_prediction;
                        conf_q  <= nn_confidence;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
`ifdef IMAGE_STREAMER_TIMEOUT_EN
                    else if (wait_cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    image_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .rd_en_i (rd_en_q),
        .rdata_i (mem_rdata),
        .data_o  (pix_data),
        .valid_o (pix_valid)
    );

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign mem_rd_en    = rd_en_q;
    assign mem_addr     = addr_q;
    assign result_digit = digit_q;
    assign result_conf  = conf_q;

`ifdef IMAGE_STREAMER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_image_streamer.sv
// Self-checking bench for image_streamer: randomized images and result timing
// compared against a simple reference model of the stream/result protocol.
module tb_image_streamer;

    localparam int NPIX = 784;
    localparam int TO   = 16;
`ifdef IMAGE_STREAMER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       mem_rd_en;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic [3:0] nn_prediction;
    logic [7:0] nn_confidence;
    logic       nn_valid;
    logic [3:0] result_digit;
    logic [7:0] result_conf;
    logic       timeout;

    image_streamer #(
        .IMG_PIXELS     (NPIX),
        .DATA_W         (8),
        .ADDR_W         (10),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .nn_prediction (nn_prediction),
        .nn_confidence (nn_confidence),
        .nn_valid      (nn_valid),
        .result_digit  (result_digit),
        .result_conf   (result_conf),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Image memory: synchronous read, data valid one cycle after the enable.
    logic [7:0] mem [NPIX];
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rdata <= (int'(mem_addr) < NPIX) ? mem[mem_addr] : 8'h00;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_digit = '0;
    logic [7:0] exp_conf  = '0;
    int run_id = 0;

    task automatic check(input string tag, input integer got, input integer exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input bit ramp);
        for (int k = 0; k < NPIX; k++)
            mem[k] = ramp ? 8'(k % 256) : 8'($urandom_range(0, 255));
    endtask

    // Called at a negedge with the DUT idle. Streams one image and checks every
    // beat against mem[]. rst_at >= 0 resets the DUT once that many beats are out.
    task automatic run_image(input bit hold_start, input bit mid_nn,
                             input int rst_at, output bit aborted);
        int acc, first, beats;
        aborted = 1'b0;
        start = 1'b1;
        @(negedge clk);
        acc = cyc;
        check("busy_after_start", busy, 1);
        check("timeout_cleared", timeout, 0);
        if (!hold_start) start = 1'b0;
        first = -1;
        beats = 0;
        for (int t = 0; t < NPIX + 10; t++) begin
            if (pix_valid) begin
                if (first < 0) first = cyc;
                if (beats < NPIX) check("pix_beat", pix_data, mem[beats]);
                beats++;
            end else if (beats > 0) begin
                break;
            end else begin
                check("pix_idle_zero", pix_data, 0);
            end
            nn_valid      = mid_nn && (beats == 100);
            nn_prediction = 4'd3;
            nn_confidence = 8'd33;
            if (beats == rst_at) begin
                nn_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_pix_valid", pix_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_rd_en", mem_rd_en, 0);
                check("rst_digit", result_digit, 0);
                exp_digit = '0;
                exp_conf  = '0;
                aborted   = 1'b1;
                $display("run %0d: reset after %0d beats", run_id, beats);
                run_id++;
                return;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        nn_valid = 1'b0;
        check("first_beat_latency", first - acc, 2);
        check("beat_count", beats, NPIX);
        check("busy_in_wait", busy, 1);
        check("no_early_done", done, 0);
        check("digit_unlatched", result_digit, exp_digit);
        check("conf_unlatched", result_conf, exp_conf);
    endtask

    // Called at the first negedge of WAIT_RES. Optionally answers with nn_valid
    // d cycles later, then checks done timing and latched results.
    task automatic wait_result(input bit respond, input int d,
                               input logic [3:0] pred, input logic [7:0] conf);
        int got, exp_k;
        bit latched, exp_to;
        got = -1;
        for (int k = 0; k < 80; k++) begin
            if (done) begin
                got = k;
                break;
            end
            nn_valid      = respond && (k == d);
            nn_prediction = pred;
            nn_confidence = conf;
            @(negedge clk);
        end
        nn_valid = 1'b0;
        latched = respond && (!TO_EN || d < TO);
        exp_to  = !latched && TO_EN;
        exp_k   = latched ? d + 1 : (TO_EN ? TO : -1);
        if (latched) begin
            exp_digit = pred;
            exp_conf  = conf;
        end
        check("done_cycle", got, exp_k);
        check("result_digit", result_digit, exp_digit);
        check("result_conf", result_conf, exp_conf);
        check("timeout_flag", timeout, exp_to);
        if (got >= 0) begin
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("busy_after_done", busy, 0);
        end else begin
            check("still_waiting", busy, 1);
        end
        $display("run %0d: done_at=%0d digit=%0d conf=%0d timeout=%0b",
                 run_id, got, result_digit, result_conf, timeout);
        run_id++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        rst           = 1'b1;
        start         = 1'b0;
        nn_valid      = 1'b0;
        nn_prediction = '0;
        nn_confidence = '0;
        fill_mem(1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_rd_en0", mem_rd_en, 0);
        check("rst_addr0", mem_addr, 0);
        check("rst_pix_data0", pix_data, 0);
        check("rst_pix_valid0", pix_valid, 0);
        check("rst_digit0", result_digit, 0);
        check("rst_conf0", result_conf, 0);
        check("rst_timeout0", timeout, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_rd_en", mem_rd_en, 0);
            check("idle_busy", busy, 0);
        end

        // Ramp image, classifier answers 9/200 two cycles into WAIT_RES.
        run_image(1'b0, 1'b0, -1, ab);
        wait_result(1'b1, 2, 4'd9, 8'd200);

        // start held high and a stray nn_valid during the stream.
        fill_mem(1'b0);
        run_image(1'b1, 1'b1, -1, ab);
        wait_result(1'b1, $urandom_range(0, 10), 4'd7, 8'($urandom_range(0, 255)));

        // Reset at pixel 400, then a clean full run from address 0.
        fill_mem(1'b0);
        @(negedge clk);
        run_image(1'b0, 1'b0, 400, ab);
        check("aborted", ab, 1);
        @(negedge clk);
        run_image(1'b0, 1'b0, -1, ab);
        wait_result(1'b1, 1, 4'($urandom_range(0, 9)), 8'($urandom_range(0, 255)));

`ifdef IMAGE_STREAMER_TIMEOUT_EN
        // No answer: timeout; then back-to-back start clears it; answer on cycle 16.
        run_image(1'b0, 1'b0, -1, ab);
        wait_result(1'b0, 0, 4'd0, 8'd0);
        run_image(1'b0, 1'b0, -1, ab);
        wait_result(1'b1, TO - 1, 4'd5, 8'd77);
`else
        // Without the timeout the streamer waits as long as it takes.
        run_image(1'b0, 1'b0, -1, ab);
        wait_result(1'b0, 0, 4'd0, 8'd0);
        wait_result(1'b1, 0, 4'd5, 8'd77);
`endif

        // Back-to-back random runs with random response delays.
        for (int r = 0; r < 3; r++) begin
            fill_mem(1'b0);
            run_image(1'b0, 1'b0, -1, ab);
            wait_result(1'b1, $urandom_range(0, 20),
                        4'($urandom_range(0, 9)), 8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
